xin_read_sequencer: RTL
=======================

Name: xin_read_sequencer

Overview:
- Read-side partner of the sample data memory.
- On each new input sample it latches the newest-sample address and turns a stream of tap offsets k into circular-buffer reads of x[n-k].
- It drives the memory read port (rd_en, data_rd_addr) and delivers a valid/ready sample stream, with a per-tap last marker, to the MAC datapath.
- If the memory reports a run of zero input samples, it skips the frame with no reads.

Parameters:
- ADDR_W, 8, memory address width; buffer depth is 2^ADDR_W and addresses wrap modulo that depth.
- DATA_W, 16, sample width.
- MAX_TAPS, 256, taps accepted per frame before the frame is force-terminated.

Ports:
- Sclk  in  1  system clock; all state changes on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: the new sample has been written at wr_ptr.
- wr_ptr  in  ADDR_W  memory address of newest sample x[n].
- zero_flag  in  1  data-memory zero-run indicator, sampled on start.
- off_valid  in  1  tap offset valid.
- off  in  ADDR_W  tap offset k.
- off_last  in  1  final offset of frame.
- off_ready  out  1  offset accepted this cycle when high with off_valid.
- rd_en  out  1  memory read enable.
- data_rd_addr  out  ADDR_W  memory read address.
- xin_data  in  DATA_W  memory read data; combinational from data_rd_addr.
- x_valid  out  1  sample output valid.
- x_data  out  DATA_W  x[n-k].
- x_last  out  1  marks the sample of the last tap.
- x_ready  in  1  downstream accepts.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- frame_zero  out  1  one-cycle pulse with done when the frame was skipped.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, Reset_n=0) forces every output and register low:
  - outputs: off_ready, rd_en, data_rd_addr, x_valid, x_data, x_last, busy, done, frame_zero, err;
  - internal registers: base, tap_cnt; FSM goes to IDLE.
- Reset mid-frame discards the frame; no done is produced.
- FSM state IDLE:
  - start with zero_flag=1 → SKIP.
  - start with zero_flag=0 → RUN; latch base<=wr_ptr; tap_cnt<=0.
- FSM state RUN:
  - busy=1.
  - off_ready = !x_valid || x_ready (single-stage pipeline).
  - Accept (off_valid && off_ready):
    - rd_en=1 combinationally, with data_rd_addr=(base-off) mod 2^ADDR_W; the wrap is plain ADDR_W-bit subtraction.
    - On that posedge: x_data<=xin_data, x_valid<=1, x_last<=off_last, tap_cnt++.
  - Read latency is one cycle from offset acceptance to x_valid.
  - No acceptance: rd_en=0, data_rd_addr holds its last value.
  - x_valid clears on x_ready when no new accept; x_data and x_last hold while x_valid && !x_ready.
  - Accepted off_last → DRAIN.
  - tap_cnt reaching MAX_TAPS without off_last → set err, force x_last on that sample, → DRAIN.
- FSM state DRAIN:
  - off_ready=0.
  - When the final sample is taken (x_valid && x_ready) → pulse done, → IDLE.
- FSM state SKIP:
  - No reads.
  - Pulse done and frame_zero together in the following cycle, → IDLE.
  - Any offsets presented are not accepted (off_ready=0); the upstream flushes them.
- start while busy (RUN/DRAIN/SKIP) is ignored and sets err; the current frame continues unchanged.
- start and done in the same cycle: done completes, start is ignored, err is set.
- off_valid in IDLE: off_ready=0, no read, no error.
- Offset k=0 reads base; k=base+1 wraps to address 2^ADDR_W-1.
- Read/write ordering: the memory writes on negedge, so a read in the cycle after start sees the new sample.

Decomposition:
- Shared package msdap_pkg holds:
  - ADDR_W/DATA_W defaults;
  - FSM state enum (IDLE, RUN, DRAIN, SKIP).
- One sub-module, circ_addr_gen: registers base, computes base-off modulo depth.
- FSM, pipeline register and counters remain in xin_read_sequencer.

Test Plan:
- Memory preloaded with addr a→a·3; start, wr_ptr=10; offsets 0,1,2 (last on 2), x_ready=1 → x_data 30,27,24 on consecutive cycles, x_last only on 24, done one cycle after the last handshake.
- wr_ptr=1; offsets 0,1,2,255 → addresses 1,0,255,2; data matches preload, no err.
- Backpressure: x_ready held low 3 cycles mid-frame → off_ready=0, x_data stable, no offset lost or duplicated; total 4 samples, in order.
- zero_flag=1 at start → rd_en never asserted; done=frame_zero=1 for exactly one cycle, 2 cycles after start.
- 300 offsets with no off_last, MAX_TAPS=256 → 256 samples, 256th with x_last=1, err=1 sticky; a second start during RUN also leaves the frame intact.
- Reset_n pulsed low mid-RUN → all outputs 0 immediately, no done; next start runs a clean frame.

Source files
------------

// File: rtl/msdap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msdap_pkg
// Brief    : Shared widths and read-sequencer FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package msdap_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int MAX_TAPS_DEF = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    SKIP  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/xin_read_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : xin_read_sequencer_if
// Brief    : Frame control, offset stream, memory read port and sample stream.
// Revision : 1.0 - initial release
// ============================================================================
interface xin_read_sequencer_if
  import msdap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              start;
  logic [ADDR_W-1:0] wr_ptr;
  logic              zero_flag;
  logic              off_valid;
  logic [ADDR_W-1:0] off;
  logic              off_last;
  logic              off_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] data_rd_addr;
  logic [DATA_W-1:0] xin_data;
  logic              x_valid;
  logic [DATA_W-1:0] x_data;
  logic              x_last;
  logic              x_ready;
  logic              busy;
  logic              done;
  logic              frame_zero;
  logic              err;

  modport master (
    output start, wr_ptr, zero_flag, off_valid, off, off_last, xin_data, x_ready,
    input  off_ready, rd_en, data_rd_addr, x_valid, x_data, x_last,
           busy, done, frame_zero, err
  );

  modport slave (
    input  start, wr_ptr, zero_flag, off_valid, off, off_last, xin_data, x_ready,
    output off_ready, rd_en, data_rd_addr, x_valid, x_data, x_last,
           busy, done, frame_zero, err
  );

endinterface
`default_nettype wire

// File: rtl/circ_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : circ_addr_gen
// Brief    : Holds the frame base address and maps tap offset k to base-k.
// Revision : 1.0 - initial release
// ============================================================================
module circ_addr_gen
  import msdap_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_wr_ptr,
  input  logic [ADDR_W-1:0] i_off,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
    end else if (i_load) begin
      r_base <= i_wr_ptr;
    end
  end

  // Natural ADDR_W-bit wraparound gives the circular-buffer modulo.
  assign o_addr = r_base - i_off;

endmodule
`default_nettype wire

// File: rtl/xin_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xin_read_sequencer
// Brief    : Turns per-frame tap offsets into x[n-k] reads and a sample stream.
// Revision : 1.0 - initial release
// ============================================================================
module xin_read_sequencer
  import msdap_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_TAPS = MAX_TAPS_DEF
) (
  input  logic                 Sclk,
  input  logic                 Reset_n,
  xin_read_sequencer_if.slave  bus
);

  localparam int c_CNT_W = $clog2(MAX_TAPS + 1);

  seq_state_e         r_state;
  seq_state_e         w_next_state;
  logic [c_CNT_W-1:0] r_tap_cnt;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W-1:0]  r_last_addr;
  logic [DATA_W-1:0]  r_x_data;
  logic               r_x_valid;
  logic               r_x_last;
  logic               r_done;
  logic               r_frame_zero;
  logic               r_err;
  logic               w_off_ready;
  logic               w_accept;
  logic               w_start_ok;
  logic               w_cap;

  // A start coinciding with done is treated like a start while busy.
  assign w_start_ok = bus.start && (r_state == IDLE) && !r_done;
  assign w_cap      = (r_tap_cnt == c_CNT_W'(MAX_TAPS - 1));

  circ_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk      (Sclk),
    .rst_n    (Reset_n),
    .i_load   (w_start_ok && !bus.zero_flag),
    .i_wr_ptr (bus.wr_ptr),
    .i_off    (bus.off),
    .o_addr   (w_rd_addr)
  );

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next_state = bus.zero_flag ? SKIP : RUN;
      RUN:     if (w_accept && (bus.off_last || w_cap)) w_next_state = DRAIN;
      DRAIN:   if (r_x_valid && bus.x_ready) w_next_state = IDLE;
      SKIP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Single-stage pipeline: a new offset may enter when the output slot frees.
  always_comb begin
    w_off_ready = 1'b0;
    if (r_state == RUN) begin
      w_off_ready = !r_x_valid || bus.x_ready;
    end
    w_accept = w_off_ready && bus.off_valid;
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tap_cnt    <= '0;
      r_last_addr  <= '0;
      r_x_data     <= '0;
      r_x_valid    <= 1'b0;
      r_x_last     <= 1'b0;
      r_done       <= 1'b0;
      r_frame_zero <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done       <= ((r_state == DRAIN) && r_x_valid && bus.x_ready) || (r_state == SKIP);
      r_frame_zero <= (r_state == SKIP);
      if ((bus.start && !w_start_ok) || (w_accept && w_cap && !bus.off_last)) begin
        r_err <= 1'b1;
      end
      if (w_start_ok) begin
        r_tap_cnt <= '0;
      end else if (w_accept) begin
        r_tap_cnt <= r_tap_cnt + 1'b1;
      end
      if (w_accept) begin
        r_x_valid   <= 1'b1;
        r_x_data    <= bus.xin_data;
        r_x_last    <= bus.off_last || w_cap;
        r_last_addr <= w_rd_addr;
      end else if (bus.x_ready) begin
        r_x_valid <= 1'b0;
      end
    end
  end

  assign bus.off_ready    = w_off_ready;
  assign bus.rd_en        = w_accept;
  assign bus.data_rd_addr = w_accept ? w_rd_addr : r_last_addr;
  assign bus.x_valid      = r_x_valid;
  assign bus.x_data       = r_x_data;
  assign bus.x_last       = r_x_last;
  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.frame_zero   = r_frame_zero;
  assign bus.err          = r_err;

endmodule
`default_nettype wire
